// File: rtl/mux4_arb_pkg.sv
// Shared types, sizes and the round-robin pick function for the
// four-source packet arbiter.
package mux4_arb_pkg;

    localparam int N_SRC = 4;
    localparam int SRC_W = 2;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // First set bit of valid, scanning ptr, ptr+1, ... modulo N_SRC.
    // Walking the offsets from far to near lets the nearest hit win.
    function automatic logic [SRC_W-1:0] rr_pick(
        input logic [N_SRC-1:0] valid,
        input logic [SRC_W-1:0] ptr
    );
        logic [SRC_W-1:0] idx;
        rr_pick = ptr;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            idx = ptr + SRC_W'(k);
            if (valid[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_mux.sv
// Combinational 4:1 data selector used to steer the granted source
// into the arbiter's output register.
module mux #(
    parameter int WIDTH = 8
) (
    input  logic [1:0]       i_sel,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_c,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_y
);

    always_comb begin
        o_y = i_a;
        unique case (i_sel)
            2'd0:    o_y = i_a;
            2'd1:    o_y = i_b;
            2'd2:    o_y = i_c;
            default: o_y = i_d;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Packet-granular round-robin arbiter: four valid/ready sources share one
// registered output channel; a grant lasts until the source's last beat.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [3:0]       i_valid,
    input  logic [WIDTH-1:0] i_data_a,
    input  logic [WIDTH-1:0] i_data_b,
    input  logic [WIDTH-1:0] i_data_c,
    input  logic [WIDTH-1:0] i_data_d,
    input  logic [3:0]       i_last,
    output logic [3:0]       o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_last,
    output logic [1:0]       o_src,
    input  logic             i_ready
);

    arb_state_t       r_state;
    arb_state_t       w_state_next;
    logic [SRC_W-1:0] r_grant;
    logic [SRC_W-1:0] w_grant_next;
    logic [SRC_W-1:0] r_rr_ptr;
    logic [SRC_W-1:0] w_rr_ptr_next;

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_last;
    logic [SRC_W-1:0] r_src;

    logic             w_busy;
    logic             w_accept;
    logic             w_xfer;
    logic             w_xfer_last;
    logic [N_SRC-1:0] w_ready;
    logic [WIDTH-1:0] w_mux_data;

    assign w_busy   = (r_state == ARB_BUSY);
    // Output slot is free, or its current beat leaves this cycle.
    assign w_accept = !r_valid || i_ready;

    // Ready is a function of state and i_ready only, never of i_valid.
    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_ready
            assign w_ready[gi] = w_busy && w_accept && (r_grant == SRC_W'(gi));
        end
    endgenerate

    assign w_xfer      = |(w_ready & i_valid);
    assign w_xfer_last = w_xfer && i_last[r_grant];

    mux #(
        .WIDTH (WIDTH)
    ) u_mux (
        .i_sel (r_grant),
        .i_a   (i_data_a),
        .i_b   (i_data_b),
        .i_c   (i_data_c),
        .i_d   (i_data_d),
        .o_y   (w_mux_data)
    );

    always_comb begin
        w_state_next  = r_state;
        w_grant_next  = r_grant;
        w_rr_ptr_next = r_rr_ptr;
        unique case (r_state)
            ARB_IDLE: begin
                if (|i_valid) begin
                    w_grant_next = rr_pick(i_valid, r_rr_ptr);
                    w_state_next = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                // Pointer moves past the winner only once its packet is done.
                if (w_xfer_last) begin
                    w_rr_ptr_next = r_grant + SRC_W'(1);
                    w_state_next  = ARB_IDLE;
                end
            end
            default: begin
                w_state_next = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ARB_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_next;
            r_grant  <= w_grant_next;
            r_rr_ptr <= w_rr_ptr_next;
        end
    end

    // Output stage: load on transfer, drain on i_ready, otherwise hold.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_src   <= '0;
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_data  <= w_mux_data;
            r_last  <= i_last[r_grant];
            r_src   <= r_grant;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_ready = w_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;
    assign o_src   = r_src;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for the round-robin packet arbiter with hand-computed
// expectations checked cycle by cycle.
module tb_mux4_rr_arbiter;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic [3:0]       valid;
    logic [WIDTH-1:0] data_a, data_b, data_c, data_d;
    logic [3:0]       last;
    logic [3:0]       o_ready;
    logic             o_valid;
    logic [WIDTH-1:0] o_data;
    logic             o_last;
    logic [1:0]       o_src;
    logic             ready;

    int checks = 0;
    int errors = 0;

    mux4_rr_arbiter #(.WIDTH(WIDTH)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid  (valid),
        .i_data_a (data_a),
        .i_data_b (data_b),
        .i_data_c (data_c),
        .i_data_d (data_d),
        .i_last   (last),
        .o_ready  (o_ready),
        .o_valid  (o_valid),
        .o_data   (o_data),
        .o_last   (o_last),
        .o_src    (o_src),
        .i_ready  (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input string tag, input logic [7:0] d, input logic l, input logic [1:0] s);
        chk({tag, "_valid"}, 32'(o_valid), 32'd1);
        chk({tag, "_data"},  32'(o_data),  32'(d));
        chk({tag, "_last"},  32'(o_last),  32'(l));
        chk({tag, "_src"},   32'(o_src),   32'(s));
    endtask

    initial begin
        rst = 1'b1; valid = 4'b0; last = 4'b0; ready = 1'b1;
        data_a = '0; data_b = '0; data_c = '0; data_d = '0;
        tick(); tick();
        #1;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_data",  32'(o_data),  32'd0);
        chk("rst_last",  32'(o_last),  32'd0);
        chk("rst_src",   32'(o_src),   32'd0);
        rst = 1'b0;
        tick();

        // Three-beat packet from source 2
        valid = 4'b0100; data_c = 8'h11; last = 4'b0000; #1;
        chk("p2_c0_ready", 32'(o_ready), 32'h0);
        chk("p2_c0_valid", 32'(o_valid), 32'd0);
        tick(); #1;
        chk("p2_c1_ready", 32'(o_ready), 32'h4);
        chk("p2_c1_valid", 32'(o_valid), 32'd0);
        tick();
        data_c = 8'h22; #1;
        beat("p2_b0", 8'h11, 1'b0, 2'd2);
        tick();
        data_c = 8'h33; last = 4'b0100; #1;
        beat("p2_b1", 8'h22, 1'b0, 2'd2);
        tick();
        valid = 4'b0000; last = 4'b0000; #1;
        beat("p2_b2", 8'h33, 1'b1, 2'd2);
        chk("p2_idle_ready", 32'(o_ready), 32'h0);
        tick(); #1;
        chk("p2_drain_valid", 32'(o_valid), 32'd0);

        // rr_ptr is now 3: sources 0 and 3 request, 3 first then 0
        valid = 4'b1001; last = 4'b1001; data_a = 8'h5A; data_d = 8'h5D; #1;
        chk("wr_idle_ready", 32'(o_ready), 32'h0);
        tick(); #1;
        chk("wr_grant3", 32'(o_ready), 32'h8);
        tick();
        valid = 4'b0001; #1;
        beat("wr_d", 8'h5D, 1'b1, 2'd3);
        chk("wr_idle2_ready", 32'(o_ready), 32'h0);
        tick(); #1;
        chk("wr_grant0", 32'(o_ready), 32'h1);
        tick();
        valid = 4'b0000; #1;
        beat("wr_a", 8'h5A, 1'b1, 2'd0);
        tick();

        // Reset to rr_ptr=0, then all four sources stream single-beat packets
        rst = 1'b1; tick(); rst = 1'b0;
        valid = 4'b1111; last = 4'b1111;
        data_a = 8'hA0; data_b = 8'hB0; data_c = 8'hC0; data_d = 8'hD0;
        for (int k = 0; k < 8; k++) begin
            logic [1:0] g;
            logic [1:0] pg;
            logic [7:0] pd;
            g  = 2'(k);
            pg = 2'(k - 1);
            pd = {2'b10, pg, 4'h0} + 8'h20;
            #1;
            chk($sformatf("rr%0d_idle_ready", k), 32'(o_ready), 32'h0);
            if (k > 0) beat($sformatf("rr%0d_prev", k), pd, 1'b1, pg);
            tick(); #1;
            chk($sformatf("rr%0d_grant", k), 32'(o_ready), 32'(4'b0001 << g));
            chk($sformatf("rr%0d_gap_valid", k), 32'(o_valid), 32'd0);
            tick();
        end
        valid = 4'b0000; #1;
        beat("rr_final", 8'hD0, 1'b1, 2'd3);
        tick();

        // Source 1 four-beat packet while source 0 waits
        valid = 4'b0010; last = 4'b0000; data_b = 8'h61; data_a = 8'h70; #1;
        chk("lk_idle_ready", 32'(o_ready), 32'h0);
        tick();
        valid = 4'b0011; last = 4'b0001; #1;
        chk("lk_b1_ready", 32'(o_ready), 32'h2);
        tick();
        data_b = 8'h62; #1;
        chk("lk_b2_ready", 32'(o_ready), 32'h2);
        beat("lk_b2", 8'h61, 1'b0, 2'd1);
        tick();
        data_b = 8'h63; #1;
        chk("lk_b3_ready", 32'(o_ready), 32'h2);
        beat("lk_b3", 8'h62, 1'b0, 2'd1);
        tick();
        data_b = 8'h64; last = 4'b0011; #1;
        chk("lk_b4_ready", 32'(o_ready), 32'h2);
        beat("lk_b4", 8'h63, 1'b0, 2'd1);
        tick();
        valid = 4'b0001; #1;
        chk("lk_i5_ready", 32'(o_ready), 32'h0);
        beat("lk_i5", 8'h64, 1'b1, 2'd1);
        tick(); #1;
        chk("lk_src0_ready", 32'(o_ready), 32'h1);
        tick();
        valid = 4'b0000; last = 4'b0000; #1;
        beat("lk_src0", 8'h70, 1'b1, 2'd0);
        tick();

        // Backpressure: i_ready low for 3 cycles mid-packet on source 2
        valid = 4'b0100; data_c = 8'h81; #1;
        tick(); #1;
        chk("bp_b1_ready", 32'(o_ready), 32'h4);
        tick();
        data_c = 8'h82; ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            beat($sformatf("bp_stall%0d", s), 8'h81, 1'b0, 2'd2);
            chk($sformatf("bp_stall%0d_ready", s), 32'(o_ready), 32'h0);
            tick();
        end
        ready = 1'b1; #1;
        beat("bp_resume", 8'h81, 1'b0, 2'd2);
        chk("bp_resume_ready", 32'(o_ready), 32'h4);
        tick();
        data_c = 8'h83; #1;
        beat("bp_b82", 8'h82, 1'b0, 2'd2);
        tick();
        data_c = 8'h84; last = 4'b0100; #1;
        beat("bp_b83", 8'h83, 1'b0, 2'd2);
        tick();
        valid = 4'b0000; last = 4'b0000; #1;
        beat("bp_b84", 8'h84, 1'b1, 2'd2);
        tick(); #1;
        chk("bp_drain_valid", 32'(o_valid), 32'd0);

        // Reset in the middle of a source-3 packet
        valid = 4'b1000; data_d = 8'h91; #1;
        tick(); #1;
        chk("rm_grant3", 32'(o_ready), 32'h8);
        tick();
        data_d = 8'h92; #1;
        beat("rm_b0", 8'h91, 1'b0, 2'd3);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; valid = 4'b1001; last = 4'b0001; data_a = 8'hA5; #1;
        chk("rm_valid", 32'(o_valid), 32'd0);
        chk("rm_ready", 32'(o_ready), 32'h0);
        chk("rm_data",  32'(o_data),  32'd0);
        tick(); #1;
        chk("rm_grant0", 32'(o_ready), 32'h1);
        tick();
        valid = 4'b0000; last = 4'b0000; #1;
        beat("rm_a", 8'hA5, 1'b1, 2'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
